// File: rtl/twoclock_pkg.sv
// Shared helpers for the dual-clock FIFO: width-generic Gray/binary conversion.
// Callers zero-extend their pointer to 32 bits and truncate the result back.
package twoclock_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper Gray bits decode to zero upper binary bits, so truncation is exact.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < GRAY_MAX_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/twoclock_gray_sync.sv
// Multi-flop synchronizer into the destination clock domain.
// Used for Gray pointers (2 stages) and, with W=1, for the 3-stage reset sync.
module twoclock_gray_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [0:STAGES-1];
  logic [W-1:0] sync_d [0:STAGES-1];

  // Shift chain: stage 0 samples the asynchronous input.
  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Chain registers, cleared by the destination-domain reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) sync_q[i] <= rst ? '0 : sync_d[i];
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/twoclock_gfifo.sv
// Dual-clock FIFO, 2**AW words of DSIZE bits, Gray-coded pointers,
// per-domain levels, almost flags and sticky overflow/underflow.
module twoclock_gfifo
  import twoclock_pkg::*;
#(
  parameter int DSIZE  = 16,
  parameter int AW     = 3,
  parameter int AFULL  = 6,
  parameter int AEMPTY = 1
) (
  input  logic             wclk,
  input  logic             wreset,
  input  logic             winc_i,
  input  logic [DSIZE-1:0] wdata_i,
  output logic             wfull_o,
  output logic             walmost_full_o,
  output logic [AW:0]      wlevel_o,
  output logic             woverflow_o,
  input  logic             rclk,
  input  logic             rinc_i,
  output logic [DSIZE-1:0] rdata_o,
  output logic             rempty_o,
  output logic             ralmost_empty_o,
  output logic [AW:0]      rlevel_o,
  output logic             runderflow_o,
  output logic             rreset_o
);

  localparam int          DEPTH     = 1 << AW;
  // Full means equal index with differing wrap bit; in Gray that is the top two bits inverted.
  localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW-1);
  localparam logic [AW:0] AFULL_L   = (AW+1)'(AFULL);
  localparam logic [AW:0] AEMPTY_L  = (AW+1)'(AEMPTY);

  logic [DSIZE-1:0] mem [0:DEPTH-1];

  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
  logic [AW:0] wq2_rgray, wq2_rbin;
  logic        wfull_q, wfull_d, woverflow_q, woverflow_d, w_push;

  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
  logic [AW:0] rq2_wgray, rq2_wbin;
  logic        rempty_q, rempty_d, runderflow_q, runderflow_d, r_pop;
  logic        rreset;

  twoclock_gray_sync #(.W(1), .STAGES(3)) u_rst_sync (
    .clk(rclk), .rst(1'b0), .d_i(wreset), .q_o(rreset)
  );

  twoclock_gray_sync #(.W(AW+1), .STAGES(2)) u_r2w_sync (
    .clk(wclk), .rst(wreset), .d_i(rgray_q), .q_o(wq2_rgray)
  );

  twoclock_gray_sync #(.W(AW+1), .STAGES(2)) u_w2r_sync (
    .clk(rclk), .rst(rreset), .d_i(wgray_q), .q_o(rq2_wgray)
  );

  // Write side next state: pointer advance, full flag and level from the next pointer.
  always_comb begin
    w_push      = winc_i & ~wfull_q;
    wbin_d      = wbin_q + {{AW{1'b0}}, w_push};
    wgray_d     = (AW+1)'(bin2gray(32'(wbin_d)));
    wq2_rbin    = (AW+1)'(gray2bin(32'(wq2_rgray)));
    wfull_d     = (wgray_d == (wq2_rgray ^ FULL_MASK));
    wlevel_d    = wbin_d - wq2_rbin;
    woverflow_d = woverflow_q | (winc_i & wfull_q);
  end

  // Write side registers.
  always_ff @(posedge wclk) begin
    if (wreset) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      wfull_q     <= 1'b0;
      wlevel_q    <= '0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      wfull_q     <= wfull_d;
      wlevel_q    <= wlevel_d;
      woverflow_q <= woverflow_d;
    end
  end

  // Storage array: written from wclk, read asynchronously; contents survive reset.
  always_ff @(posedge wclk) begin
    if (w_push) mem[wbin_q[AW-1:0]] <= wdata_i;
  end

  // Read side next state: pointer advance, empty flag and level from the next pointer.
  always_comb begin
    r_pop        = rinc_i & ~rempty_q;
    rbin_d       = rbin_q + {{AW{1'b0}}, r_pop};
    rgray_d      = (AW+1)'(bin2gray(32'(rbin_d)));
    rq2_wbin     = (AW+1)'(gray2bin(32'(rq2_wgray)));
    rempty_d     = (rgray_d == rq2_wgray);
    rlevel_d     = rq2_wbin - rbin_d;
    runderflow_d = runderflow_q | (rinc_i & rempty_q);
  end

  // Read side registers, held in reset by the synchronized rclk-domain reset.
  always_ff @(posedge rclk) begin
    if (rreset) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rempty_q     <= rempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign wfull_o         = wfull_q;
  assign wlevel_o        = wlevel_q;
  assign walmost_full_o  = (wlevel_q >= AFULL_L);
  assign woverflow_o     = woverflow_q;
  assign rdata_o         = mem[rbin_q[AW-1:0]];
  assign rempty_o        = rempty_q;
  assign rlevel_o        = rlevel_q;
  assign ralmost_empty_o = (rlevel_q <= AEMPTY_L);
  assign runderflow_o    = runderflow_q;
  assign rreset_o        = rreset;

endmodule

// File: tb/tb_twoclock_gfifo.sv
// Scoreboard bench for twoclock_gfifo: depth 4, wclk 10 ns, rclk 17 ns then 4 ns.
`timescale 1ns/100ps
module tb_twoclock_gfifo;

  localparam int DSIZE  = 16;
  localparam int AW     = 2;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic             wclk = 1'b0;
  logic             rclk = 1'b0;
  logic             wreset = 1'b1;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             wfull_o, walmost_full_o, woverflow_o;
  logic [AW:0]      wlevel_o, rlevel_o;
  logic [DSIZE-1:0] rdata_o;
  logic             rempty_o, ralmost_empty_o, runderflow_o, rreset_o;

  real         rhalf = 8.5;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];

  twoclock_gfifo #(.DSIZE(DSIZE), .AW(AW), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
    .wclk(wclk), .wreset(wreset), .winc_i(winc), .wdata_i(wdata),
    .wfull_o(wfull_o), .walmost_full_o(walmost_full_o), .wlevel_o(wlevel_o),
    .woverflow_o(woverflow_o),
    .rclk(rclk), .rinc_i(rinc), .rdata_o(rdata_o), .rempty_o(rempty_o),
    .ralmost_empty_o(ralmost_empty_o), .rlevel_o(rlevel_o),
    .runderflow_o(runderflow_o), .rreset_o(rreset_o)
  );

  always #5 wclk = ~wclk;
  // Offset keeps rclk edges off the integer-ns wclk edges.
  initial begin
    #0.3;
    forever #(rhalf) rclk = ~rclk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called 1 ns after a wclk edge; the word is expected only if the FIFO is not full.
  task automatic wr(input logic [DSIZE-1:0] v);
    if (!wfull_o) sb_q.push_back(32'(v));
    winc  = 1'b1;
    wdata = v;
    @(posedge wclk); #1;
    winc  = 1'b0;
  endtask

  // Called 1 ns after an rclk edge; checks head word then pops it.
  task automatic rd(input string tag);
    logic [31:0] exp;
    chk("rd_nonempty", rempty_o, 0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, 32'(rdata_o), exp);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
  endtask

  task automatic do_reset();
    int i;
    @(posedge wclk); #1;
    wreset = 1'b1;
    @(posedge wclk); #1;
    chk("rst_wlevel", wlevel_o, 0);
    chk("rst_wfull", wfull_o, 0);
    chk("rst_walmost_full", walmost_full_o, 0);
    chk("rst_woverflow", woverflow_o, 0);
    repeat (12) @(posedge wclk);
    #1;
    chk("rst_rreset_hi", rreset_o, 1);
    wreset = 1'b0;
    sb_q.delete();
    i = 0;
    while (rreset_o === 1'b1 && i < 20) begin
      @(posedge rclk); #1;
      i++;
    end
    chk("rst_rreset_lo", rreset_o, 0);
    chk("rst_rempty", rempty_o, 1);
    chk("rst_rlevel", rlevel_o, 0);
    chk("rst_ralmost_empty", ralmost_empty_o, 1);
    chk("rst_runderflow", runderflow_o, 0);
  endtask

  task automatic case_fill();
    @(posedge wclk); #1;
    chk("c2_wovf_pre", woverflow_o, 0);
    for (int k = 1; k <= 4; k++) begin
      wr(16'hA000 + 16'(k));
      chk("c2_wlevel", wlevel_o, k);
      chk("c2_walmost_full", walmost_full_o, (k >= AFULL));
      chk("c2_wfull", wfull_o, (k == 4));
    end
    winc  = 1'b1;
    wdata = 16'hDEAD;
    @(posedge wclk); #1;
    winc  = 1'b0;
    chk("c2_woverflow", woverflow_o, 1);
    chk("c2_wlevel_full", wlevel_o, 4);
    chk("c2_wfull_hold", wfull_o, 1);
    repeat (4) @(posedge rclk);
    #1;
    chk("c2_rlevel", rlevel_o, 4);
    chk("c2_rempty", rempty_o, 0);
    chk("c2_ralmost_empty", ralmost_empty_o, 0);
  endtask

  task automatic case_drain();
    int n;
    @(posedge rclk); #1;
    chk("c3_head", 32'(rdata_o), 32'hA001);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          rd("c3_data");
          chk("c3_rlevel", rlevel_o, 3 - k);
          chk("c3_ralmost_empty", ralmost_empty_o, ((3 - k) <= AEMPTY));
        end
      end
      begin
        wait (rinc === 1'b1);
        @(posedge rclk);
        n = 0;
        while (n < 3) begin
          @(posedge wclk); #1;
          n++;
          if (!wfull_o) break;
        end
        chk("c3_wfull_fall", wfull_o, 0);
      end
    join
    chk("c3_rempty", rempty_o, 1);
    chk("c3_runderflow_pre", runderflow_o, 0);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    chk("c3_runderflow", runderflow_o, 1);
    chk("c3_rempty_hold", rempty_o, 1);
    chk("c3_rlevel_zero", rlevel_o, 0);
  endtask

  task automatic case_stream();
    int n_wr;
    int n_rd;
    n_wr = 0;
    n_rd = 0;
    fork
      begin
        int wcyc;
        wcyc = 0;
        @(posedge wclk); #1;
        while (n_wr < 1000 && wcyc < 8000) begin
          if ($urandom_range(1) == 1 && !wfull_o) begin
            chk("c4_wlevel_pess", 32'(wlevel_o >= sb_q.size()), 1);
            sb_q.push_back(32'(16'(n_wr)));
            winc  = 1'b1;
            wdata = 16'(n_wr);
            n_wr++;
          end else begin
            winc = 1'b0;
          end
          @(posedge wclk); #1;
          wcyc++;
        end
        winc = 1'b0;
      end
      begin
        int rcyc;
        logic [31:0] exp;
        rcyc = 0;
        @(posedge rclk); #1;
        while (n_rd < 1000 && rcyc < 9000) begin
          if ($urandom_range(1) == 1 && !rempty_o) begin
            chk("c4_rlevel_pess", 32'(rlevel_o <= sb_q.size()), 1);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            chk("c4_data", 32'(rdata_o), exp);
            rinc = 1'b1;
            n_rd++;
          end else begin
            rinc = 1'b0;
          end
          @(posedge rclk); #1;
          rcyc++;
        end
        rinc = 1'b0;
      end
    join
    chk("c4_wr_count", n_wr, 1000);
    chk("c4_rd_count", n_rd, 1000);
    chk("c4_sb_empty", sb_q.size(), 0);
    repeat (4) @(posedge rclk);
    #1;
    chk("c4_rempty_end", rempty_o, 1);
  endtask

  task automatic case_single();
    int n;
    @(posedge wclk); #1;
    fork
      wr(16'h1234);
      begin
        wait (winc === 1'b1);
        @(posedge wclk);
        n = 0;
        while (n < 3) begin
          @(posedge rclk); #1;
          n++;
          if (!rempty_o) break;
        end
        chk("c5_rempty_fall", rempty_o, 0);
      end
    join
    @(posedge rclk); #1;
    chk("c5_rdata", 32'(rdata_o), 32'h1234);
    chk("c5_rlevel", rlevel_o, 1);
    chk("c5_ralmost_empty", ralmost_empty_o, 1);
    rd("c5_pop");
    chk("c5_rempty_after", rempty_o, 1);
  endtask

  task automatic case_reset_mid();
    @(posedge wclk); #1;
    wr(16'hB001);
    wr(16'hB002);
    wr(16'hB003);
    chk("c6_wlevel_pre", wlevel_o, 3);
    chk("c6_woverflow_sticky", woverflow_o, 1);
    repeat (4) @(posedge rclk);
    #1;
    chk("c6_rlevel_pre", rlevel_o, 3);
    chk("c6_runderflow_sticky", runderflow_o, 1);
    do_reset();
  endtask

  initial begin
    do_reset();
    case_fill();
    case_drain();
    case_stream();
    case_single();
    case_reset_mid();
    rhalf = 2.0;
    case_fill();
    case_drain();
    case_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
